instruction_issue: RTL and testbench

Issue stage directly downstream of the instruction memory. Consumes `inst`/`inst_valid`, drives `advance_pointer` back to the memory's program counter, and buffers fetched instructions in a 2-entry FIFO. Instructions are presented to the execution datapath over a valid/ready handshake, with an outstanding-instruction limit. A SYNC barrier opcode drains all in-flight work before issue resumes.

---
 rtl/instruction_issue_if.sv | 24 ++
 rtl/instruction_issue.sv | 116 +++++++++++
 tb/tb_instruction_issue.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_issue_if.sv
// Issue-side handshake between the issue stage and the execution datapath:
// instruction/valid/ready, plus the retire pulse that comes back from execution.
interface instruction_issue_if #(
    parameter int DW = 32
);
    logic [DW-1:0] issue_inst;
    logic          issue_valid;
    logic          issue_ready;
    logic          retire;

    modport master (
        output issue_inst,
        output issue_valid,
        input  issue_ready,
        input  retire
    );

    modport slave (
        input  issue_inst,
        input  issue_valid,
        output issue_ready,
        output retire
    );
endinterface

// File: rtl/instruction_issue.sv
// Issue stage: 2-entry fetch FIFO, outstanding-instruction limiter and a
// SYNC barrier that drains all in-flight work before issue resumes.
module instruction_issue #(
    parameter int              FULL_INSTRUCTION_BITWIDTH = 32,
    parameter int              IMEM_ADDR_WIDTH           = 8,
    parameter int              DW                        = FULL_INSTRUCTION_BITWIDTH,
    parameter int              OPW                       = 4,
    parameter logic [OPW-1:0]  SYNC_OPCODE               = 4'hF,
    parameter int              MAX_OUTSTANDING           = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DW-1:0]              inst,
    input  logic                       inst_valid,
    output logic                       advance_pointer,
    instruction_issue_if.master        bus,
    output logic [IMEM_ADDR_WIDTH-1:0] issued_count,
    output logic                       idle,
    output logic                       retire_err
);

    localparam int            OW    = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0] MAX_O = OW'(MAX_OUTSTANDING);

    typedef enum logic {RUN, DRAIN} state_t;

    state_t          state;
    logic [DW-1:0]   mem [0:1];
    logic [1:0]      fifo_count;
    logic            rd_ptr;
    logic            wr_ptr;
    logic [OW-1:0]   outstanding;
    logic [OW-1:0]   outstanding_nxt;

    logic [DW-1:0]   head;
    logic            head_sync;
    logic            push;
    logic            pop;
    logic            handshake;
    logic            sync_pop;

    assign head      = mem[rd_ptr];
    assign head_sync = (head[DW-1 -: OPW] == SYNC_OPCODE);

    // Fetch looks only at the registered count, never at downstream ready/retire.
    assign advance_pointer = rst_n && inst_valid && (fifo_count < 2'd2);
    assign push            = advance_pointer;

    assign bus.issue_valid = (state == RUN) && (fifo_count != 2'd0) && !head_sync &&
                             (outstanding < MAX_O);
    // Gated by valid so a parked SYNC head is never visible downstream.
    assign bus.issue_inst  = bus.issue_valid ? head : '0;

    assign handshake = bus.issue_valid && bus.issue_ready;
    assign sync_pop  = (state == DRAIN) && (outstanding == '0);
    assign pop       = handshake || sync_pop;

    assign idle = (fifo_count == 2'd0) && (outstanding == '0) && !inst_valid;

    always_comb begin
        outstanding_nxt = outstanding;
        if (handshake && !bus.retire)
            outstanding_nxt = outstanding + 1'b1;
        else if (!handshake && bus.retire && (outstanding != '0))
            outstanding_nxt = outstanding - 1'b1;
        else if (handshake && bus.retire && (outstanding == '0))
            outstanding_nxt = OW'(1);
    end

    // FIFO storage is pure data and is left unreset; validity comes from fifo_count.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= inst;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            fifo_count   <= 2'd0;
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
            outstanding  <= '0;
            issued_count <= '0;
            retire_err   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase

            outstanding <= outstanding_nxt;
            if (handshake)
                issued_count <= issued_count + 1'b1;
            if (bus.retire && (outstanding == '0))
                retire_err <= 1'b1;

            case (state)
                RUN: begin
                    if ((fifo_count != 2'd0) && head_sync)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (outstanding == '0)
                        state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_issue.sv
// Directed bench for instruction_issue: streaming, backpressure, outstanding
// limit, SYNC barrier, simultaneous issue/retire, retire error and mid-run reset.
module tb_instruction_issue;

    localparam int DW = 32;
    localparam int AW = 8;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] inst;
    logic          inst_valid;
    logic          advance_pointer;
    logic [AW-1:0] issued_count;
    logic          idle;
    logic          retire_err;

    instruction_issue_if #(.DW(DW)) bus ();

    instruction_issue #(
        .FULL_INSTRUCTION_BITWIDTH(DW),
        .IMEM_ADDR_WIDTH(AW),
        .OPW(4),
        .SYNC_OPCODE(4'hF),
        .MAX_OUTSTANDING(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .inst(inst),
        .inst_valid(inst_valid),
        .advance_pointer(advance_pointer),
        .bus(bus),
        .issued_count(issued_count),
        .idle(idle),
        .retire_err(retire_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] prog [0:15];
    int            n_prog;
    int            pc;
    int            cyc_no;
    logic          rdy;
    logic          ret;
    logic          s_adv, s_vld, s_hs;
    logic [DW-1:0] s_inst;
    logic [DW-1:0] issued_q [$];
    int            issue_cyc [$];

    // One clock cycle: drive inputs, sample outputs mid-cycle, then advance the
    // instruction-memory model if the DUT consumed the current instruction.
    task automatic cyc();
        inst_valid      = (pc < n_prog);
        inst            = (pc < n_prog) ? prog[pc] : '0;
        bus.issue_ready = rdy;
        bus.retire      = ret;
        #1;
        s_adv  = advance_pointer;
        s_vld  = bus.issue_valid;
        s_inst = bus.issue_inst;
        s_hs   = s_vld && rdy;
        if (s_hs) begin
            issued_q.push_back(s_inst);
            issue_cyc.push_back(cyc_no);
        end
        @(posedge clk);
        #1;
        if (s_adv) pc++;
        cyc_no++;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; rdy = 1'b0; ret = 1'b0;
        inst_valid = 1'b0; inst = '0;
        bus.issue_ready = 1'b0; bus.retire = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pc = 0; cyc_no = 0; n_prog = 0;
        issued_q.delete();
        issue_cyc.delete();
    endtask

    task automatic load_prog(input int n, input logic [3:0] sync_at_op_idx);
        n_prog = n;
        for (int i = 0; i < n; i++)
            prog[i] = {4'(i + 1), 20'h0, 8'(8'hA0 + i)};
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        inst_valid = 1'b1; inst = 32'h1234_5678;
        bus.issue_ready = 1'b1; bus.retire = 1'b0;
        #3;
        n_cmp++; if (advance_pointer !== 1'b0) begin n_err++; $display("FAIL reset_adv: got %b expected 0", advance_pointer); end
        n_cmp++; if (bus.issue_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", bus.issue_valid); end
        n_cmp++; if (bus.issue_inst !== '0) begin n_err++; $display("FAIL reset_inst: got %h expected 0", bus.issue_inst); end
        n_cmp++; if (issued_count !== '0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", issued_count); end
        n_cmp++; if (retire_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b expected 0", retire_err); end
        inst_valid = 1'b0;
        #1;
        n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL reset_idle: got %b expected 1", idle); end
    endtask

    task automatic test_streaming();
        logic prev;
        apply_reset();
        load_prog(8, 4'h0);
        prev = 1'b0;
        for (int k = 0; k < 12; k++) begin
            rdy = 1'b1; ret = prev;
            cyc();
            prev = s_hs;
        end
        n_cmp++; if (issued_q.size() !== 8) begin n_err++; $display("FAIL stream_num: got %0d expected 8", issued_q.size()); end
        for (int i = 0; i < 8 && i < issued_q.size(); i++) begin
            n_cmp++; if (issue_cyc[i] !== i + 1) begin n_err++; $display("FAIL stream_cycle[%0d]: got %0d expected %0d", i, issue_cyc[i], i + 1); end
            n_cmp++; if (issued_q[i] !== prog[i]) begin n_err++; $display("FAIL stream_inst[%0d]: got %h expected %h", i, issued_q[i], prog[i]); end
        end
        n_cmp++; if (issued_count !== 8'd8) begin n_err++; $display("FAIL stream_count: got %0d expected 8", issued_count); end
        n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL stream_idle: got %b expected 1", idle); end
        n_cmp++; if (retire_err !== 1'b0) begin n_err++; $display("FAIL stream_err: got %b expected 0", retire_err); end
    endtask

    task automatic test_backpressure();
        int unstable;
        int adv_high;
        logic prev;
        apply_reset();
        load_prog(5, 4'h0);
        unstable = 0; adv_high = 0;
        for (int k = 0; k < 10; k++) begin
            rdy = 1'b0; ret = 1'b0;
            cyc();
            if (k >= 1 && (s_vld !== 1'b1 || s_inst !== prog[0])) unstable++;
            if (k >= 2 && s_adv !== 1'b0) adv_high++;
        end
        n_cmp++; if (unstable !== 0) begin n_err++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", unstable); end
        n_cmp++; if (adv_high !== 0) begin n_err++; $display("FAIL bp_adv_full: got %0d cycles high expected 0", adv_high); end
        n_cmp++; if (pc !== 2) begin n_err++; $display("FAIL bp_fill: got %0d fetched expected 2", pc); end
        prev = 1'b0;
        for (int k = 0; k < 12; k++) begin
            rdy = 1'b1; ret = prev;
            cyc();
            prev = s_hs;
        end
        n_cmp++; if (issued_q.size() !== 5) begin n_err++; $display("FAIL bp_num: got %0d expected 5", issued_q.size()); end
        for (int i = 0; i < 5 && i < issued_q.size(); i++) begin
            n_cmp++; if (issued_q[i] !== prog[i]) begin n_err++; $display("FAIL bp_inst[%0d]: got %h expected %h", i, issued_q[i], prog[i]); end
        end
    endtask

    task automatic test_outstanding();
        apply_reset();
        load_prog(7, 4'h0);
        for (int k = 0; k < 10; k++) begin
            rdy = 1'b1; ret = 1'b0;
            cyc();
        end
        n_cmp++; if (issued_q.size() !== 4) begin n_err++; $display("FAIL lim_num: got %0d expected 4", issued_q.size()); end
        n_cmp++; if (s_vld !== 1'b0) begin n_err++; $display("FAIL lim_valid: got %b expected 0", s_vld); end
        rdy = 1'b1; ret = 1'b1;
        cyc();
        for (int k = 0; k < 6; k++) begin
            rdy = 1'b1; ret = 1'b0;
            cyc();
        end
        n_cmp++; if (issued_q.size() !== 5) begin n_err++; $display("FAIL lim_one_more: got %0d expected 5", issued_q.size()); end
        if (issued_q.size() == 5) begin
            n_cmp++; if (issue_cyc[4] !== 11) begin n_err++; $display("FAIL lim_cycle: got %0d expected 11", issue_cyc[4]); end
            n_cmp++; if (issued_q[4] !== prog[4]) begin n_err++; $display("FAIL lim_inst: got %h expected %h", issued_q[4], prog[4]); end
        end
        n_cmp++; if (s_vld !== 1'b0) begin n_err++; $display("FAIL lim_valid2: got %b expected 0", s_vld); end
        n_cmp++; if (issued_count !== 8'd5) begin n_err++; $display("FAIL lim_count: got %0d expected 5", issued_count); end
    endtask

    task automatic test_sync();
        int sync_seen;
        apply_reset();
        n_prog = 4;
        prog[0] = 32'h1000_00A0;
        prog[1] = 32'h2000_00B0;
        prog[2] = 32'hF000_0000;
        prog[3] = 32'h3000_00C0;
        sync_seen = 0;
        for (int k = 0; k < 14; k++) begin
            rdy = 1'b1; ret = 1'b0;
            foreach (issue_cyc[i]) if (issue_cyc[i] + 5 == cyc_no) ret = 1'b1;
            cyc();
            if (s_inst[31:28] === 4'hF) sync_seen++;
        end
        n_cmp++; if (issued_q.size() !== 3) begin n_err++; $display("FAIL sync_num: got %0d expected 3", issued_q.size()); end
        if (issued_q.size() == 3) begin
            n_cmp++; if (issued_q[0] !== 32'h1000_00A0) begin n_err++; $display("FAIL sync_a: got %h expected 100000a0", issued_q[0]); end
            n_cmp++; if (issued_q[1] !== 32'h2000_00B0) begin n_err++; $display("FAIL sync_b: got %h expected 200000b0", issued_q[1]); end
            n_cmp++; if (issued_q[2] !== 32'h3000_00C0) begin n_err++; $display("FAIL sync_c: got %h expected 300000c0", issued_q[2]); end
            // A,B retire in cycles 6,7; outstanding hits 0 in 8 (SYNC pop), C issues in 9.
            n_cmp++; if (issue_cyc[2] !== 9) begin n_err++; $display("FAIL sync_c_cycle: got %0d expected 9", issue_cyc[2]); end
        end
        n_cmp++; if (sync_seen !== 0) begin n_err++; $display("FAIL sync_visible: got %0d cycles expected 0", sync_seen); end
        n_cmp++; if (issued_count !== 8'd3) begin n_err++; $display("FAIL sync_count: got %0d expected 3", issued_count); end
    endtask

    task automatic test_simultaneous_and_error();
        apply_reset();
        load_prog(8, 4'h0);
        for (int k = 0; k < 8; k++) begin
            rdy = 1'b1; ret = (cyc_no == 4);
            cyc();
        end
        n_cmp++; if (issued_q.size() !== 5) begin n_err++; $display("FAIL simul_num: got %0d expected 5", issued_q.size()); end
        if (issued_q.size() == 5) begin
            n_cmp++; if (issue_cyc[4] !== 5) begin n_err++; $display("FAIL simul_cycle: got %0d expected 5", issue_cyc[4]); end
        end
        n_cmp++; if (retire_err !== 1'b0) begin n_err++; $display("FAIL simul_err: got %b expected 0", retire_err); end

        apply_reset();
        n_cmp++; if (retire_err !== 1'b0) begin n_err++; $display("FAIL err_pre: got %b expected 0", retire_err); end
        rdy = 1'b0; ret = 1'b1;
        cyc();
        for (int k = 0; k < 3; k++) begin
            rdy = 1'b0; ret = 1'b0;
            cyc();
        end
        n_cmp++; if (retire_err !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b expected 1", retire_err); end
        n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL err_idle: got %b expected 1", idle); end
    endtask

    task automatic test_reset_mid_stream();
        apply_reset();
        load_prog(8, 4'h0);
        for (int k = 0; k < 4; k++) begin
            rdy = 1'b1; ret = 1'b0;
            cyc();
        end
        for (int k = 0; k < 2; k++) begin
            rdy = 1'b0; ret = 1'b0;
            cyc();
        end
        #1;
        n_cmp++; if (issued_count !== 8'd3) begin n_err++; $display("FAIL mid_pre_count: got %0d expected 3", issued_count); end
        n_cmp++; if (advance_pointer !== 1'b0) begin n_err++; $display("FAIL mid_pre_full: got %b expected 0", advance_pointer); end
        n_cmp++; if (bus.issue_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre_valid: got %b expected 1", bus.issue_valid); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.issue_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b expected 0", bus.issue_valid); end
        n_cmp++; if (bus.issue_inst !== '0) begin n_err++; $display("FAIL mid_inst: got %h expected 0", bus.issue_inst); end
        n_cmp++; if (advance_pointer !== 1'b0) begin n_err++; $display("FAIL mid_adv: got %b expected 0", advance_pointer); end
        n_cmp++; if (issued_count !== '0) begin n_err++; $display("FAIL mid_count: got %0d expected 0", issued_count); end
        inst_valid = 1'b0;
        #1;
        n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL mid_idle: got %b expected 1", idle); end
        apply_reset();
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_outstanding();
        test_sync();
        test_simultaneous_and_error();
        test_reset_mid_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
